// File: rtl/srlatch_ctrl.sv
// Sequencer/arbiter that drives one shared SR latch from a set-side and a reset-side requester.
// Issues a registered s/r pulse, waits a guard gap, then verifies q/q_bar and reports ack or err.
module srlatch_ctrl #(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic set_req,
    input  logic rst_req,
    input  logic q,
    input  logic q_bar,
    output logic s,
    output logic r,
    output logic busy,
    output logic set_ack,
    output logic rst_ack,
    output logic err
);

    localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OP_SET = 1'b0,
        OP_RST = 1'b1
    } op_t;

    state_t           state, state_nxt;
    op_t              op, op_nxt;
    op_t              prio, prio_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             s_nxt, r_nxt, busy_nxt;
    logic             set_ack_nxt, rst_ack_nxt, err_nxt;
    logic             feedback_ok;

    // A latch that reports q == q_bar is never a match, whichever side was granted.
    assign feedback_ok = (op == OP_SET) ? (q & ~q_bar) : (~q & q_bar);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_nxt   = state;
        op_nxt      = op;
        prio_nxt    = prio;
        cnt_nxt     = cnt;
        s_nxt       = 1'b0;
        r_nxt       = 1'b0;
        set_ack_nxt = 1'b0;
        rst_ack_nxt = 1'b0;
        err_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (set_req || rst_req) begin
                    if (set_req && rst_req) begin
                        op_nxt   = prio;
                        prio_nxt = (prio == OP_SET) ? OP_RST : OP_SET;
                    end else begin
                        op_nxt = set_req ? OP_SET : OP_RST;
                    end
                    state_nxt = PULSE;
                    cnt_nxt   = CNT_W'(1);
                    s_nxt     = (op_nxt == OP_SET);
                    r_nxt     = (op_nxt == OP_RST);
                end
            end

            PULSE: begin
                if (cnt == CNT_W'(PULSE_W)) begin
                    state_nxt = GAP;
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    s_nxt   = (op == OP_SET);
                    r_nxt   = (op == OP_RST);
                end
            end

            GAP: begin
                if (cnt == CNT_W'(GAP_W)) begin
                    state_nxt   = DONE;
                    set_ack_nxt = feedback_ok && (op == OP_SET);
                    rst_ack_nxt = feedback_ok && (op == OP_RST);
                    err_nxt     = ~feedback_ok;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            DONE: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // NOTE: state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            op      <= OP_SET;
            prio    <= OP_SET;
            cnt     <= '0;
            s       <= 1'b0;
            r       <= 1'b0;
            busy    <= 1'b0;
            set_ack <= 1'b0;
            rst_ack <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            op      <= op_nxt;
            prio    <= prio_nxt;
            cnt     <= cnt_nxt;
            s       <= s_nxt;
            r       <= r_nxt;
            busy    <= busy_nxt;
            set_ack <= set_ack_nxt;
            rst_ack <= rst_ack_nxt;
            err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_srlatch_ctrl.sv
// Closed-loop bench: srlatch_ctrl driving a behavioural SR latch, checked against a
// timeline model (cycles since grant) on every falling edge plus directed literal checks.
module tb_srlatch_ctrl;

    localparam int P = 2;
    localparam int G = 1;

    logic clk     = 1'b0;
    logic reset   = 1'b0;
    logic set_req = 1'b0;
    logic rst_req = 1'b0;
    logic q, q_bar;
    logic s, r, busy, set_ack, rst_ack, err;

    logic latch_q   = 1'b0;
    logic force_bad = 1'b0;

    int total = 0;
    int bad   = 0;

    srlatch_ctrl #(.PULSE_W(P), .GAP_W(G)) dut (
        .clk     (clk),
        .reset   (reset),
        .set_req (set_req),
        .rst_req (rst_req),
        .q       (q),
        .q_bar   (q_bar),
        .s       (s),
        .r       (r),
        .busy    (busy),
        .set_ack (set_ack),
        .rst_ack (rst_ack),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Behavioural SR latch; force_bad models a broken latch reporting q == q_bar == 1.
    always @(s or r) begin
        if (s)      latch_q = 1'b1;
        else if (r) latch_q = 1'b0;
    end
    assign q     = force_bad ? 1'b1 : latch_q;
    assign q_bar = force_bad ? 1'b1 : ~latch_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_t = cycles since the grant edge (-1 when idle). An operation spans
    // edges 0..P+G; the check result is latched at edge P+G from pre-edge feedback.
    int m_t        = -1;
    bit m_prio_set = 1'b1;
    bit m_op_set   = 1'b1;
    bit m_ok       = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_t        = -1;
            m_prio_set = 1'b1;
        end else if (m_t < 0) begin
            if (set_req || rst_req) begin
                if (set_req && rst_req) begin
                    m_op_set   = m_prio_set;
                    m_prio_set = !m_prio_set;
                end else begin
                    m_op_set = set_req;
                end
                m_t = 0;
            end
        end else if (m_t == P + G) begin
            m_t = -1;
        end else begin
            m_t++;
            if (m_t == P + G)
                m_ok = m_op_set ? (q && !q_bar) : (!q && q_bar);
        end
    end

    // Observation log for directed checks.
    int  cyc = 0;
    int  n_set_ack = 0, n_rst_ack = 0, n_err = 0, n_s_rise = 0;
    byte rise_ops[$];
    int  rise_cyc[$];
    logic prev_s = 1'b0, prev_r = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic e_s, e_r, e_busy, e_sa, e_ra, e_err;
        e_s    = (m_t >= 0) && (m_t < P) && m_op_set;
        e_r    = (m_t >= 0) && (m_t < P) && !m_op_set;
        e_busy = (m_t >= 0);
        e_sa   = (m_t == P + G) && m_ok && m_op_set;
        e_ra   = (m_t == P + G) && m_ok && !m_op_set;
        e_err  = (m_t == P + G) && !m_ok;
        check("s",       s,       e_s);
        check("r",       r,       e_r);
        check("busy",    busy,    e_busy);
        check("set_ack", set_ack, e_sa);
        check("rst_ack", rst_ack, e_ra);
        check("err",     err,     e_err);
        check("s_and_r", s & r,   1'b0);
        if (set_ack) n_set_ack++;
        if (rst_ack) n_rst_ack++;
        if (err)     n_err++;
        if (s && !prev_s) begin
            n_s_rise++;
            rise_ops.push_back("S");
            rise_cyc.push_back(cyc);
        end
        if (r && !prev_r) rise_ops.push_back("R");
        prev_s = s;
        prev_r = r;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int b_sa, b_ra, b_err, b_rise;

        #1 reset = 1'b1;
        tick(2);
        reset = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_s", s, 0);
        check("reset_r", r, 0);

        // Single SET from idle: s high 2 cycles, 1 gap cycle, ack, idle.
        set_req = 1'b1;
        tick();
        set_req = 1'b0;
        check("set_t0_s", s, 1);
        check("set_t0_busy", busy, 1);
        tick();
        check("set_t1_s", s, 1);
        tick();
        check("set_gap_s", s, 0);
        check("set_gap_busy", busy, 1);
        tick();
        check("set_done_ack", set_ack, 1);
        check("set_done_err", err, 0);
        check("set_q", q, 1);
        tick();
        check("set_idle_ack", set_ack, 0);
        check("set_idle_busy", busy, 0);

        // Back-to-back SET with q already 1: full pulses, acks, 5-cycle period.
        b_sa = n_set_ack; b_err = n_err; b_rise = n_s_rise;
        rise_cyc.delete();
        set_req = 1'b1;
        tick(10);
        set_req = 1'b0;
        tick(2);
        check("b2b_acks", n_set_ack - b_sa, 2);
        check("b2b_errs", n_err - b_err, 0);
        check("b2b_pulses", n_s_rise - b_rise, 2);
        if (rise_cyc.size() == 2) check("b2b_period", rise_cyc[1] - rise_cyc[0], 5);
        else check("b2b_rise_log", rise_cyc.size(), 2);

        // Contended requests: round robin starting from SET.
        b_sa = n_set_ack; b_ra = n_rst_ack; b_err = n_err;
        rise_ops.delete();
        set_req = 1'b1;
        rst_req = 1'b1;
        tick(20);
        set_req = 1'b0;
        rst_req = 1'b0;
        tick(2);
        check("rr_grants", rise_ops.size(), 4);
        if (rise_ops.size() == 4) begin
            check("rr_op0", rise_ops[0], "S");
            check("rr_op1", rise_ops[1], "R");
            check("rr_op2", rise_ops[2], "S");
            check("rr_op3", rise_ops[3], "R");
        end
        check("rr_set_acks", n_set_ack - b_sa, 2);
        check("rr_rst_acks", n_rst_ack - b_ra, 2);
        check("rr_errs", n_err - b_err, 0);
        check("rr_q_final", q, 0);

        // RST with broken feedback q=q_bar=1 -> err, no rst_ack.
        force_bad = 1'b1;
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        tick(3);
        check("bad_fb_err", err, 1);
        check("bad_fb_rst_ack", rst_ack, 0);
        tick();
        check("bad_fb_err_clr", err, 0);
        check("bad_fb_busy", busy, 0);
        force_bad = 1'b0;

        // set_req asserted only while in GAP is ignored.
        b_rise = n_s_rise; b_ra = n_rst_ack;
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        tick(2);
        set_req = 1'b1;
        tick();
        set_req = 1'b0;
        tick(4);
        check("gap_req_busy", busy, 0);
        check("gap_req_no_pulse", n_s_rise - b_rise, 0);
        check("gap_req_rst_ack", n_rst_ack - b_ra, 1);

        // Reset mid-PULSE of a SET: s drops at once, no ack afterwards.
        b_sa = n_set_ack; b_err = n_err;
        set_req = 1'b1;
        tick();
        set_req = 1'b0;
        tick();
        check("abort_pre_s", s, 1);
        #2 reset = 1'b1;
        #1;
        check("abort_s", s, 0);
        check("abort_busy", busy, 0);
        tick();
        reset = 1'b0;
        b_rise = n_s_rise;
        tick(6);
        check("abort_no_ack", n_set_ack - b_sa, 0);
        check("abort_no_err", n_err - b_err, 0);
        check("abort_no_pulse", n_s_rise - b_rise, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
